// File: rtl/gear_selector_fsm_if.sv
// ---------------------------------------------------------------------------
// gear_selector_fsm_if
// Groups the operator-side request buttons, the brake/speed interlock levels
// and the selector outputs of gear_selector_fsm into one bundle.
//   master : drives P/N/R/D/DN/brake/zero_speed, observes the selector outputs
//   slave  : the selector itself
// Signals:
//   P, N, R, D, DN      request buttons (levels, synchronous to clk)
//   brake, zero_speed   interlock levels
//   gear_d              one-hot drive gear (bit k-1 = gear k), 0 outside Drive
//   P1, N1, R1          one-hot mode indicators
//   M1, M0              mode code 00 Park, 01 Neutral, 10 Reverse, 11 Drive
//   gear_num            binary drive gear, 0 outside Drive
//   reject              one-cycle pulse for a refused request
// ---------------------------------------------------------------------------
interface gear_selector_fsm_if #(
    parameter int NUM_GEARS = 4
);
    localparam int GW = $clog2(NUM_GEARS + 1);

    logic                 P;
    logic                 N;
    logic                 R;
    logic                 D;
    logic                 DN;
    logic                 brake;
    logic                 zero_speed;
    logic [NUM_GEARS-1:0] gear_d;
    logic                 P1;
    logic                 N1;
    logic                 R1;
    logic                 M1;
    logic                 M0;
    logic [GW-1:0]        gear_num;
    logic                 reject;

    modport master (
        output P, N, R, D, DN, brake, zero_speed,
        input  gear_d, P1, N1, R1, M1, M0, gear_num, reject
    );

    modport slave (
        input  P, N, R, D, DN, brake, zero_speed,
        output gear_d, P1, N1, R1, M1, M0, gear_num, reject
    );
endinterface

// File: rtl/gear_selector_fsm.sv
// ---------------------------------------------------------------------------
// gear_selector_fsm
// PRND gear selector with NUM_GEARS drive gears (2..8), optional upshift
// wrap-around and brake / zero-speed interlocks. Button rising edges are
// requests; every output is a flop loaded from the decoded next state.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset, forces PARK
//   bus    gear_selector_fsm_if slave modport (buttons in, selector out)
// Parameters:
//   NUM_GEARS  number of drive gears, must match the interface instance
//   WRAP       0: upshift at top gear is rejected; 1: wraps to gear 1
// ---------------------------------------------------------------------------
module gear_selector_fsm #(
    parameter int NUM_GEARS = 4,
    parameter int WRAP      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    gear_selector_fsm_if.slave        bus
);
    localparam int GW = $clog2(NUM_GEARS + 1);

    // Encoding equals the external M1/M0 code.
    typedef enum logic [1:0] {
        MODE_PARK    = 2'b00,
        MODE_NEUTRAL = 2'b01,
        MODE_REVERSE = 2'b10,
        MODE_DRIVE   = 2'b11
    } mode_t;

    mode_t                mode_q, mode_d;
    logic [GW-1:0]        gsel_q, gsel_d;      // drive gear 1..N, 0 outside Drive
    logic [4:0]           prev_q;              // {P,N,R,D,DN} of the last cycle
    logic [NUM_GEARS-1:0] gear_oh_q, gear_oh_d;
    logic                 p1_q, n1_q, r1_q;
    logic                 reject_q, reject_d;

    logic [4:0] btn;
    logic [4:0] req;
    logic       multi_req;
    logic       req_p, req_n, req_r, req_d, req_dn;

    assign btn       = {bus.P, bus.N, bus.R, bus.D, bus.DN};
    assign req       = btn & ~prev_q;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_req = (req & (req - 5'd1)) != 5'd0;
    assign {req_p, req_n, req_r, req_d, req_dn} = req;

    always_comb begin
        mode_d   = mode_q;
        gsel_d   = gsel_q;
        reject_d = 1'b0;
        if (multi_req) begin
            reject_d = 1'b1;
        end else begin
            case (mode_q)
                MODE_PARK: begin
                    if (req_n) begin
                        if (bus.brake) mode_d = MODE_NEUTRAL;
                        else           reject_d = 1'b1;
                    end else if (req_d) begin
                        if (bus.brake) begin
                            mode_d = MODE_DRIVE;
                            gsel_d = GW'(1);
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (req_r) begin
                        if (bus.brake && bus.zero_speed) mode_d = MODE_REVERSE;
                        else                             reject_d = 1'b1;
                    end else if (req_dn) begin
                        reject_d = 1'b1;
                    end
                end
                MODE_NEUTRAL: begin
                    if (req_d) begin
                        mode_d = MODE_DRIVE;
                        gsel_d = GW'(1);
                    end else if (req_r) begin
                        if (bus.zero_speed) mode_d = MODE_REVERSE;
                        else                reject_d = 1'b1;
                    end else if (req_p) begin
                        if (bus.zero_speed) mode_d = MODE_PARK;
                        else                reject_d = 1'b1;
                    end else if (req_dn) begin
                        reject_d = 1'b1;
                    end
                end
                MODE_REVERSE: begin
                    if (req_n) begin
                        mode_d = MODE_NEUTRAL;
                    end else if (req_p) begin
                        if (bus.zero_speed) mode_d = MODE_PARK;
                        else                reject_d = 1'b1;
                    end else if (req_d) begin
                        if (bus.zero_speed) begin
                            mode_d = MODE_DRIVE;
                            gsel_d = GW'(1);
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (req_dn) begin
                        reject_d = 1'b1;
                    end
                end
                default: begin // MODE_DRIVE
                    if (req_d) begin
                        if (gsel_q < GW'(NUM_GEARS)) gsel_d = gsel_q + GW'(1);
                        else if (WRAP != 0)          gsel_d = GW'(1);
                        else                         reject_d = 1'b1;
                    end else if (req_dn) begin
                        if (gsel_q > GW'(1)) gsel_d = gsel_q - GW'(1);
                        else                 reject_d = 1'b1;
                    end else if (req_n) begin
                        mode_d = MODE_NEUTRAL;
                        gsel_d = '0;
                    end else if (req_p || req_r) begin
                        if (bus.zero_speed) begin
                            mode_d = req_p ? MODE_PARK : MODE_REVERSE;
                            gsel_d = '0;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // One-hot gear decode of the next state; gsel_d is 0 outside Drive.
    generate
        for (genvar gi = 0; gi < NUM_GEARS; gi++) begin : g_onehot
            assign gear_oh_d[gi] = (gsel_d == GW'(gi + 1));
        end
    endgenerate

    // Previous-value flops reset high so a button held through reset
    // does not look like a fresh press when reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_PARK;
            gsel_q    <= '0;
            prev_q    <= '1;
            gear_oh_q <= '0;
            p1_q      <= 1'b1;
            n1_q      <= 1'b0;
            r1_q      <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            gsel_q    <= gsel_d;
            prev_q    <= btn;
            gear_oh_q <= gear_oh_d;
            p1_q      <= (mode_d == MODE_PARK);
            n1_q      <= (mode_d == MODE_NEUTRAL);
            r1_q      <= (mode_d == MODE_REVERSE);
            reject_q  <= reject_d;
        end
    end

    assign bus.gear_d   = gear_oh_q;
    assign bus.P1       = p1_q;
    assign bus.N1       = n1_q;
    assign bus.R1       = r1_q;
    assign bus.M1       = mode_q[1];
    assign bus.M0       = mode_q[0];
    assign bus.gear_num = gsel_q;
    assign bus.reject   = reject_q;
endmodule
